tx_burst_scheduler: RTL and testbench



---
 rtl/tx_burst_scheduler_if.sv | 32 +++
 rtl/tx_burst_scheduler.sv | 99 +++++++++
 tb/tb_tx_burst_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_burst_scheduler_if.sv
// tx_burst_scheduler_if: modulator strobe, descriptor and payload-bit handshakes plus slot/burst status.
interface tx_burst_scheduler_if #(
    parameter int SLOTS = 8,
    parameter int LEN_BITS = 8
);
    localparam int SW = $clog2(SLOTS);
    logic next_symbol_strobe;
    logic current_symbol;
    logic sched_valid;
    logic sched_ready;
    logic [SW-1:0] sched_slot;
    logic [LEN_BITS-1:0] sched_len;
    logic bit_valid;
    logic bit_data;
    logic bit_ready;
    logic [SW-1:0] slot_index;
    logic [7:0] sym_count;
    logic burst_active;
    logic burst_done;
    logic desc_error;
    logic underrun;
    modport master (
        output next_symbol_strobe, sched_valid, sched_slot, sched_len, bit_valid, bit_data,
        input current_symbol, sched_ready, bit_ready, slot_index, sym_count,
        input burst_active, burst_done, desc_error, underrun
    );
    modport slave (
        input next_symbol_strobe, sched_valid, sched_slot, sched_len, bit_valid, bit_data,
        output current_symbol, sched_ready, bit_ready, slot_index, sym_count,
        output burst_active, burst_done, desc_error, underrun
    );
endinterface

// File: rtl/tx_burst_scheduler.sv
// tx_burst_scheduler: TDMA burst sequencer emitting head tail, payload bits and trail tail in a target slot.
module tx_burst_scheduler #(
    parameter int SYMS_PER_SLOT = 156,
    parameter int SLOTS = 8,
    parameter int TAIL_SYMS = 3,
    parameter int LEN_BITS = 8,
    parameter logic IDLE_SYMBOL = 1'b1
) (
    input logic clock,
    input logic reset,
    tx_burst_scheduler_if.slave bus
);
    localparam int SW = $clog2(SLOTS);
    localparam logic [7:0] LAST_SYM = 8'(SYMS_PER_SLOT - 1);
    localparam logic [LEN_BITS-1:0] TAIL = LEN_BITS'(TAIL_SYMS);
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(SYMS_PER_SLOT - 2 * TAIL_SYMS);
    localparam logic [LEN_BITS-1:0] ONE = LEN_BITS'(1);

    typedef enum logic [2:0] {IDLE, ARMED, HEAD, PAYLOAD, TRAIL} state_t;
    state_t state;
    logic strobe_q;
    logic [SW-1:0] slot_q;
    logic [SW-1:0] next_slot;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] cnt;
    logic sev;
    logic boundary;
    logic take;
    logic bad_len;

    assign sev = bus.next_symbol_strobe && !strobe_q;
    assign boundary = sev && bus.sym_count == LAST_SYM;
    assign next_slot = bus.slot_index + 1'b1;
    // a payload bit slot is consumed on the last head sev and on every payload sev but the one entering trail
    assign take = sev && ((state == HEAD && cnt == TAIL) || (state == PAYLOAD && cnt != len_q));
    assign bad_len = bus.sched_len == '0 || bus.sched_len > MAX_LEN;
    assign bus.sched_ready = state == IDLE;
    assign bus.bit_ready = take && bus.bit_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            strobe_q <= 1'b1;
            slot_q <= '0;
            len_q <= '0;
            cnt <= '0;
            bus.sym_count <= '0;
            bus.slot_index <= '0;
            bus.current_symbol <= IDLE_SYMBOL;
            bus.burst_active <= 1'b0;
            bus.burst_done <= 1'b0;
            bus.desc_error <= 1'b0;
            bus.underrun <= 1'b0;
        end else begin
            strobe_q <= bus.next_symbol_strobe;
            bus.burst_done <= 1'b0;
            bus.desc_error <= 1'b0;
            if (sev) begin
                bus.sym_count <= boundary ? 8'd0 : bus.sym_count + 8'd1;
                bus.current_symbol <= take && bus.bit_valid ? bus.bit_data : IDLE_SYMBOL;
            end
            if (boundary) bus.slot_index <= next_slot;
            if (take && !bus.bit_valid) bus.underrun <= 1'b1;
            case (state)
                IDLE: if (bus.sched_valid) begin
                    if (bad_len) bus.desc_error <= 1'b1;
                    else begin
                        slot_q <= bus.sched_slot;
                        len_q <= bus.sched_len;
                        bus.underrun <= 1'b0;
                        state <= ARMED;
                    end
                end
                ARMED: if (boundary && next_slot == slot_q) begin
                    state <= HEAD;
                    bus.burst_active <= 1'b1;
                    cnt <= ONE;
                end
                HEAD: if (sev) begin
                    cnt <= cnt == TAIL ? ONE : cnt + ONE;
                    if (cnt == TAIL) state <= PAYLOAD;
                end
                PAYLOAD: if (sev) begin
                    cnt <= cnt == len_q ? ONE : cnt + ONE;
                    if (cnt == len_q) state <= TRAIL;
                end
                TRAIL: if (sev) begin
                    cnt <= cnt + ONE;
                    if (cnt == TAIL) begin
                        state <= IDLE;
                        bus.burst_active <= 1'b0;
                        bus.burst_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_burst_scheduler.sv
// tb_tx_burst_scheduler: absolute-symbol-number model with per-cycle compare plus directed literal checks.
module tb_tx_burst_scheduler;
    localparam int SPS = 156;
    localparam int T = 3;
    localparam int FRAME = SPS * 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    tx_burst_scheduler_if bus ();
    tx_burst_scheduler dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: n counts symbol events since reset; a burst occupies events s .. s+2T+len-1
    int n = 0;
    int s = -1;
    int m_len = 0;
    int m_slot = 0;
    bit busy = 1'b0;
    bit m_prev = 1'b1;
    bit cmp_en = 1'b0;
    logic e_sym = 1'b1, e_active = 1'b0, e_done = 1'b0, e_err = 1'b0, e_under = 1'b0;
    logic e_bit_ready = 1'b0, d_bit_ready = 1'b0;
    logic [7:0] src_bits = 8'h00;
    logic [7:0] src_valid = 8'hff;

    always @(posedge clock) begin
        bit sev, rdy;
        int k, p;
        d_bit_ready = bus.bit_ready;
        e_done = 1'b0;
        e_err = 1'b0;
        e_bit_ready = 1'b0;
        if (!reset) begin
            n = 0; s = -1; busy = 1'b0; m_prev = 1'b1;
            e_sym = 1'b1; e_active = 1'b0; e_under = 1'b0;
        end else begin
            sev = bus.next_symbol_strobe && !m_prev;
            m_prev = bus.next_symbol_strobe;
            rdy = !busy;
            if (sev) begin
                n++;
                k = n - s;
                p = k - T;
                e_sym = 1'b1;
                if (busy && k >= 0 && k < 2 * T + m_len) begin
                    e_active = 1'b1;
                    if (p >= 0 && p < m_len) begin
                        e_bit_ready = bus.bit_valid;
                        if (bus.bit_valid) e_sym = bus.bit_data;
                        else e_under = 1'b1;
                    end
                end else if (busy && k == 2 * T + m_len) begin
                    e_active = 1'b0; e_done = 1'b1; busy = 1'b0;
                end
            end
            if (rdy && bus.sched_valid) begin
                if (bus.sched_len == 0 || int'(bus.sched_len) > SPS - 2 * T) e_err = 1'b1;
                else begin
                    busy = 1'b1;
                    m_len = int'(bus.sched_len);
                    m_slot = int'(bus.sched_slot);
                    e_under = 1'b0;
                    s = (n / SPS + 1) * SPS;
                    while ((s / SPS) % 8 != m_slot) s += SPS;
                end
            end
        end
    end

    // payload source: presents the bit for the payload position of the next symbol event
    always @(negedge clock) begin
        int p;
        p = n + 1 - s - T;
        if (busy && p >= 0 && p < m_len && p < 8) begin
            bus.bit_valid = src_valid[p];
            bus.bit_data = src_bits[p];
        end else begin
            bus.bit_valid = 1'b1;
            bus.bit_data = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("sym_count", 32'(bus.sym_count), n % SPS);
            chk("slot_index", 32'(bus.slot_index), (n / SPS) % 8);
            chk("current_symbol", 32'(bus.current_symbol), 32'(e_sym));
            chk("burst_active", 32'(bus.burst_active), 32'(e_active));
            chk("burst_done", 32'(bus.burst_done), 32'(e_done));
            chk("desc_error", 32'(bus.desc_error), 32'(e_err));
            chk("underrun", 32'(bus.underrun), 32'(e_under));
            chk("sched_ready", 32'(bus.sched_ready), 32'(!busy));
            chk("bit_ready", 32'(d_bit_ready), 32'(e_bit_ready));
        end
    end

    int br_cnt = 0, done_cnt = 0, err_cnt = 0;
    always @(posedge clock) begin
        if (bus.bit_ready) br_cnt++;
        if (bus.burst_done) done_cnt++;
        if (bus.desc_error) err_cnt++;
    end

    int tn = 0;
    task automatic sev_pulse(input int hold = 1);
        @(negedge clock);
        bus.next_symbol_strobe = 1'b1;
        repeat (hold) @(negedge clock);
        bus.next_symbol_strobe = 1'b0;
        tn++;
    endtask

    task automatic goto_boundary_of(input int slot);
        while (!((tn % SPS) == SPS - 1 && ((tn / SPS) + 1) % 8 == slot)) sev_pulse();
    endtask

    task automatic send_desc(input int slot, input int len);
        @(negedge clock);
        bus.sched_valid = 1'b1;
        bus.sched_slot = 3'(slot);
        bus.sched_len = 8'(len);
        @(negedge clock);
        bus.sched_valid = 1'b0;
    endtask

    task automatic capture(input int cnt, output logic [15:0] seq, output int act);
        seq = '0;
        act = 0;
        for (int i = 0; i < cnt; i++) begin
            sev_pulse();
            seq = {seq[14:0], bus.current_symbol};
            if (bus.burst_active) act++;
        end
    endtask

    initial begin
        logic [15:0] seq;
        int act, b;
        bit started;
        bus.next_symbol_strobe = 1'b1;
        bus.sched_valid = 1'b0;
        bus.sched_slot = '0;
        bus.sched_len = '0;
        repeat (3) @(negedge clock);
        cmp_en = 1'b1;
        chk("reset_ready", 32'(bus.sched_ready), 1);
        chk("reset_symbol", 32'(bus.current_symbol), 1);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("held_strobe_sym", 32'(bus.sym_count), 0);
        bus.next_symbol_strobe = 1'b0;

        src_bits = 8'b0000_1101;
        src_valid = 8'hff;
        send_desc(2, 4);
        for (int i = 0; i < SPS; i++) sev_pulse(i == 10 ? 3 : 1);
        chk("wrap_sym", 32'(bus.sym_count), 0);
        chk("wrap_slot", 32'(bus.slot_index), 1);
        goto_boundary_of(2);
        br_cnt = 0;
        done_cnt = 0;
        capture(10, seq, act);
        chk("burst_seq", 32'(seq), 32'b11_1101_1111);
        chk("active_syms", act, 10);
        sev_pulse();
        @(negedge clock);
        chk("done_count", done_cnt, 1);
        chk("bit_ready_count", br_cnt, 4);

        src_bits = 8'h00;
        src_valid = 8'b1111_1101;
        send_desc(3, 4);
        goto_boundary_of(3);
        br_cnt = 0;
        capture(10, seq, act);
        chk("gap_seq", 32'(seq), 32'b11_1010_0111);
        sev_pulse();
        @(negedge clock);
        chk("gap_underrun", 32'(bus.underrun), 1);
        chk("gap_bit_ready_count", br_cnt, 3);
        chk("gap_done_count", done_cnt, 2);

        src_valid = 8'hff;
        send_desc(0, 0);
        send_desc(0, 151);
        @(negedge clock);
        chk("bad_err_count", err_cnt, 2);
        chk("bad_ready", 32'(bus.sched_ready), 1);
        chk("bad_keeps_underrun", 32'(bus.underrun), 1);

        src_bits = 8'b0000_0010;
        goto_boundary_of(1);
        @(negedge clock);
        bus.next_symbol_strobe = 1'b1;
        bus.sched_valid = 1'b1;
        bus.sched_slot = 3'd1;
        bus.sched_len = 8'd2;
        @(negedge clock);
        bus.next_symbol_strobe = 1'b0;
        bus.sched_valid = 1'b0;
        tn++;
        b = tn;
        started = 1'b0;
        for (int i = 0; i < FRAME + 10 && !started; i++) begin
            sev_pulse();
            if (bus.burst_active) started = 1'b1;
        end
        chk("frame_later_start", tn - b, FRAME);
        repeat (8) sev_pulse();
        @(negedge clock);
        chk("frame_done_count", done_cnt, 3);

        src_bits = 8'ha5;
        send_desc(5, 8);
        goto_boundary_of(5);
        repeat (5) sev_pulse();
        chk("mid_payload_active", 32'(bus.burst_active), 1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_active", 32'(bus.burst_active), 0);
        chk("rst_symbol", 32'(bus.current_symbol), 1);
        chk("rst_slot", 32'(bus.slot_index), 0);
        chk("rst_ready", 32'(bus.sched_ready), 1);
        reset = 1'b1;
        tn = 0;
        repeat (20) sev_pulse();
        @(negedge clock);
        chk("rst_no_done", done_cnt, 3);
        chk("rst_sym_after", 32'(bus.sym_count), 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected under 2000000", $time);
        $fatal(1, "watchdog");
    end
endmodule
